// File: rtl/loader_pkg.sv
// Shared constants for the instruction loader: FSM encoding, debounce default, display layout.
package loader_pkg;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WRITE    = 3'd1;
   localparam logic [2:0] READ     = 3'd2;
   localparam logic [2:0] CHECK    = 3'd3;
   localparam logic [2:0] INC      = 3'd4;
   localparam logic [2:0] WAIT_REL = 3'd5;

   // 10 ms at 50 MHz
   localparam int unsigned DEBOUNCE_CYC_DEFAULT = 500000;

   localparam int unsigned DISP_PTR_LSB  = 24;
   localparam int unsigned DISP_PTR_W    = 8;
   localparam int unsigned DISP_DATA_LSB = 0;
   localparam int unsigned DISP_DATA_W   = 16;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a one-cycle
// strobe on each accepted release-to-press (1->0) transition.
module key_debounce
   import loader_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
   input  logic CLOCK_50,
   input  logic RESET,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         level   <= 1'b1;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= key_n;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         // Count only while the synced input disagrees with the accepted level.
         if (sync_q2 == level) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            level <= sync_q2;
            cnt_q <= '0;
            press <= level;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Operator-driven instruction RAM writer. Define INST_LOADER_READBACK_EN to add a
// read-after-write verify pass (mem_q input, sticky verify_err output).
module inst_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   input  logic              wr_key_n,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              run,
`ifdef INST_LOADER_READBACK_EN
   input  logic [DATA_W-1:0] mem_q,
   output logic              verify_err,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              busy,
   output logic [31:0]       disp
);

   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic              key_level;
   logic              key_press;
   logic [2:0]        state_q;
   logic [2:0]        state_d;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] ptr_inc;
   logic [ADDR_W:0]   count_inc;
   logic [31:0]       ptr_ext;
   logic [31:0]       data_ext;
   logic [31:0]       disp_d;

   key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_key (
      .CLOCK_50(CLOCK_50),
      .RESET   (RESET),
      .key_n   (wr_key_n),
      .level   (key_level),
      .press   (key_press)
   );

   assign ptr_inc   = wr_ptr_q + 1'b1;
   assign count_inc = count + 1'b1;
   assign ptr_ext   = 32'(ptr_inc);
   assign data_ext  = 32'(mem_data);
   assign busy      = (state_q != IDLE);
   // Gated by RESET so a reset landing on the WRITE cycle suppresses the write.
   assign mem_wren  = (state_q == WRITE) && !RESET;

   always_comb begin
      disp_d = '0;
      disp_d[DISP_PTR_LSB +: DISP_PTR_W]   = ptr_ext[DISP_PTR_W-1:0];
      disp_d[DISP_DATA_LSB +: DISP_DATA_W] = data_ext[DISP_DATA_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (key_press) state_d = (!run && !full) ? WRITE : WAIT_REL;
`ifdef INST_LOADER_READBACK_EN
         WRITE:    state_d = READ;
         READ:     state_d = CHECK;
         CHECK:    state_d = INC;
`else
         WRITE:    state_d = INC;
`endif
         INC:      state_d = WAIT_REL;
         WAIT_REL: if (key_level) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         mem_addr <= '0;
         mem_data <= '0;
         count    <= '0;
         full     <= 1'b0;
         disp     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && key_press && !run && !full) begin
            mem_data <= sw_data;
            mem_addr <= wr_ptr_q;
         end
         if (state_q == INC) begin
            wr_ptr_q <= ptr_inc;
            disp     <= disp_d;
            if (count != FULL_CNT) count <= count_inc;
            if (count_inc == FULL_CNT) full <= 1'b1;
         end
      end
   end

`ifdef INST_LOADER_READBACK_EN
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         verify_err <= 1'b0;
      end else if (state_q == CHECK && mem_q != mem_data) begin
         verify_err <= 1'b1;
      end
   end
`endif

endmodule
